echo_detector: RTL
==================

ECHO_DETECTOR -- requirements
Module: echo_detector

Interface
REQ-001 SHALL have parameter DW, default 16, meaning signed PCM sample width.
REQ-002 SHALL have parameter CW, default 16, meaning sample-counter, time-of-flight, blank and window width.
REQ-003 SHALL have port clk  in  1  system clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port ce_pcm  in  1  one-cycle PCM sample strobe from the filter chain.
REQ-006 SHALL have port pcm_i  in  DW  signed filtered sample, valid when ce_pcm=1.
REQ-007 SHALL have port start  in  1  one-cycle pulse marking ping emission.
REQ-008 SHALL have port mclear  in  1  synchronous abort/clear.
REQ-009 SHALL have port threshold  in  DW-1  unsigned magnitude threshold.
REQ-010 SHALL have port blank_len  in  CW  samples ignored after start.
REQ-011 SHALL have port win_len  in  CW  listen-window length in samples.
REQ-012 SHALL have port hits_req  in  3  consecutive over-threshold samples needed; 0 is treated as 1.
REQ-013 SHALL have ports busy, done, echo_found (out, 1 each): measurement active; one-cycle completion pulse; echo-detected flag.
REQ-014 SHALL have ports tof (out, CW) and peak (out, DW-1): index of the first sample of the qualifying run; maximum magnitude seen while listening.

Function
REQ-015 SHALL implement states IDLE, BLANK, LISTEN, DONE; busy=1 in BLANK and LISTEN only.
REQ-016 IDLE: start=1 -> BLANK; cnt, hit counter and peak cleared; echo_found and tof cleared. start SHALL be ignored outside IDLE.
REQ-017 cnt SHALL increment by 1 on each ce_pcm in BLANK and LISTEN, saturating at 2^CW-1; the current sample index equals cnt before the increment.
REQ-018 A ce_pcm in the same cycle as the accepted start SHALL NOT be counted.
REQ-019 BLANK: samples ignored; SHALL go to LISTEN in the cycle when cnt >= blank_len; blank_len=0 enters LISTEN the cycle after start.
REQ-020 mag SHALL equal |pcm_i|, saturating; -2^(DW-1) maps to 2^(DW-1)-1.
REQ-021 LISTEN, on ce_pcm: if mag > peak, update peak; if mag >= threshold, increment hit and record the run-start index when hit was 0; otherwise clear hit.
REQ-022 When hit reaches max(hits_req,1), the FSM SHALL latch tof = run-start index, set echo_found=1, and go to DONE.
REQ-023 Window end SHALL be blank_len+win_len, computed at CW+1 bits and saturated to 2^CW-1.
REQ-024 On reaching the window end without detection: go to DONE, echo_found=0, tof=all-ones.
REQ-025 If detection and window end coincide on the same sample, detection SHALL win.
REQ-026 threshold=0: every listened sample is a hit.
REQ-027 DONE SHALL assert done for exactly one cycle, then return to IDLE; done rises the cycle after the qualifying ce_pcm.
REQ-028 tof, peak and echo_found SHALL hold until the next accepted start, mclear, or rst.
REQ-029 mclear=1 in any state: go to IDLE next cycle; done is not pulsed; tof, peak, echo_found, cnt and hit are cleared.
REQ-030 mclear SHALL take priority over a simultaneous start.

Reset
REQ-031 rst SHALL force state IDLE, busy=0, done=0, echo_found=0, tof=0, peak=0, cnt=0, hit=0, with priority over all inputs.
REQ-032 rst asserted mid-measurement SHALL abort without a done pulse.

Verification
REQ-033 Bench settings blank_len=10, win_len=100, threshold=1000, hits_req=3. Stimulus: start, then samples zero except indices 40-42 = +1500 -> done one cycle after sample 42; echo_found=1, tof=40, peak=1500.
REQ-034 Same settings; samples at indices 5-7 = 30000, then all zero -> samples ignored during blanking; done after sample 109; echo_found=0, tof=0xFFFF, peak=0.
REQ-035 hits_req=2; samples 20=1200, 21=0, 22=-1300, 23=-32768 -> run restarts at 22; tof=22, peak=32767.
REQ-036 mclear pulsed at sample index 30 during LISTEN -> busy=0 next cycle; no done pulse; outputs zero; a new start is accepted immediately.
REQ-037 start and ce_pcm in the same cycle, blank_len=0, hits_req=0, threshold=0 -> first counted sample is the next ce_pcm; tof=0; echo_found=1.
REQ-038 blank_len=0xFFF0, win_len=0x0100 -> window end saturates at 0xFFFF; timeout tof=0xFFFF; cnt does not wrap.

Source files
------------

// File: rtl/echo_detector.sv
// -----------------------------------------------------------------------------
// echo_detector
// Sonar/ultrasonic echo detector. After a ping (start) the block ignores
// blank_len samples, then listens for win_len samples looking for hits_req
// consecutive samples whose magnitude reaches threshold. It reports the index
// of the first sample of the qualifying run (tof), the largest magnitude seen
// while listening (peak) and whether an echo was found.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   ce_pcm, pcm_i   one-cycle sample strobe and signed sample
//   start           one-cycle ping-emission pulse (accepted in IDLE only)
//   mclear          synchronous abort/clear, wins over start
//   threshold       unsigned magnitude threshold
//   blank_len       samples ignored after start
//   win_len         listen-window length in samples
//   hits_req        consecutive hits needed (0 behaves as 1)
//   busy            measurement in progress
//   done            one-cycle completion pulse
//   echo_found      echo detected flag (held)
//   tof             run-start index, all-ones on timeout (held)
//   peak            maximum magnitude while listening (held)
// -----------------------------------------------------------------------------
module echo_detector #(
   parameter int DW = 16,
   parameter int CW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce_pcm,
   input  logic signed [DW-1:0] pcm_i,
   input  logic                 start,
   input  logic                 mclear,
   input  logic [DW-2:0]        threshold,
   input  logic [CW-1:0]        blank_len,
   input  logic [CW-1:0]        win_len,
   input  logic [2:0]           hits_req,
   output logic                 busy,
   output logic                 done,
   output logic                 echo_found,
   output logic [CW-1:0]        tof,
   output logic [DW-2:0]        peak
);

   typedef enum logic [1:0] {IDLE, BLANK, LISTEN, DONE} state_t;

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;
   logic [2:0]    hit_reg;
   logic [CW-1:0] run_start_reg;
   logic          busy_reg;
   logic          done_reg;
   logic          echo_reg;
   logic [CW-1:0] tof_reg;
   logic [DW-2:0] peak_reg;

   // Window end at CW+1 bits so a large blank+window saturates instead of wrapping.
   logic [CW:0]   wend_sum;
   logic [CW-1:0] wend;
   assign wend_sum = {1'b0, blank_len} + {1'b0, win_len};
   assign wend     = wend_sum[CW] ? '1 : wend_sum[CW-1:0];

   logic [CW-1:0] cnt_inc;
   assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + CW'(1);

   // Saturating magnitude: negating the most negative value overflows back to
   // itself (MSB still set), which is mapped to the largest positive magnitude.
   logic [DW-1:0] pcm_neg;
   logic [DW-2:0] mag;
   assign pcm_neg = -pcm_i;
   always_comb begin
      mag = pcm_i[DW-2:0];
      if (pcm_i[DW-1]) begin
         mag = pcm_neg[DW-1] ? '1 : pcm_neg[DW-2:0];
      end
   end

   logic [2:0] hreq;
   assign hreq = (hits_req == 3'd0) ? 3'd1 : hits_req;

   // The sample arriving in the cycle blanking ends is already a listen sample,
   // so back-to-back strobes never lose the first listened index.
   logic listening;
   assign listening = (state_reg == LISTEN) ||
                      ((state_reg == BLANK) && (cnt_reg >= blank_len));

   logic          over;
   logic [3:0]    hit_inc;
   logic [CW-1:0] run_idx;
   logic          detect;
   logic          timeout;
   assign over    = (mag >= threshold);
   assign hit_inc = {1'b0, hit_reg} + 4'd1;
   assign run_idx = (hit_reg == 3'd0) ? cnt_reg : run_start_reg;
   assign detect  = listening && ce_pcm && over && (hit_inc >= {1'b0, hreq});
   assign timeout = listening && (ce_pcm ? (cnt_inc >= wend) : (cnt_reg >= wend));

   always_ff @(posedge clk) begin
      if (rst || mclear) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         hit_reg       <= '0;
         run_start_reg <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         echo_reg      <= 1'b0;
         tof_reg       <= '0;
         peak_reg      <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  state_reg     <= BLANK;
                  busy_reg      <= 1'b1;
                  cnt_reg       <= '0;
                  hit_reg       <= '0;
                  run_start_reg <= '0;
                  peak_reg      <= '0;
                  echo_reg      <= 1'b0;
                  tof_reg       <= '0;
               end
            end
            BLANK, LISTEN: begin
               if (ce_pcm) begin
                  cnt_reg <= cnt_inc;
               end
               if (listening) begin
                  state_reg <= LISTEN;
                  if (ce_pcm) begin
                     if (mag > peak_reg) begin
                        peak_reg <= mag;
                     end
                     if (over) begin
                        hit_reg       <= hit_inc[2:0];
                        run_start_reg <= run_idx;
                     end else begin
                        hit_reg <= '0;
                     end
                  end
                  // Detection is evaluated first so it wins over a coincident window end.
                  if (detect) begin
                     state_reg <= DONE;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                     echo_reg  <= 1'b1;
                     tof_reg   <= run_idx;
                  end else if (timeout) begin
                     state_reg <= DONE;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                     echo_reg  <= 1'b0;
                     tof_reg   <= '1;
                  end
               end
            end
            DONE: begin
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy       = busy_reg;
   assign done       = done_reg;
   assign echo_found = echo_reg;
   assign tof        = tof_reg;
   assign peak       = peak_reg;

endmodule
